wb_port_arbiter: RTL and testbench

- Shares the single register-file write port among NREQ writeback requesters: pipeline WB, multi-cycle mul/div unit, and load-miss return.
- Drives wr_en/wr_addr/wr_data into the register file. Each register in the file is a bank of 64 enable flops.
- Grants each cycle with fixed priority for the pipeline and round-robin for the others.
- A starvation guard forces a grant to a slow unit and stalls the pipeline.

---
 rtl/wb_arb_pkg.sv | 14 +
 rtl/rr_picker.sv | 34 +++
 rtl/wb_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types, default widths and helpers for the register-file writeback port arbiter.
package wb_arb_pkg;

    typedef enum logic {Normal, Force} state_t;

    localparam int unsigned AW       = 5;
    localparam int unsigned DW       = 64;
    localparam int unsigned ZERO_REG = 31;

    function automatic logic [31:0] idx_to_onehot(input int unsigned idx);
        return 32'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker over requesters 1..N-1; requester 0 is handled by the caller.
module rr_picker
    import wb_arb_pkg::*;
#(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:1]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [31:0] oh;
    int          cand;

    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = 1;
        // Walk the slow requesters starting at ptr, wrapping N-1 back to 1.
        for (int off = 0; off < int'(N) - 1; off++) begin
            cand = ((int'(ptr) - 1 + off) % (int'(N) - 1)) + 1;
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = IW'(cand);
            end
        end
        oh  = idx_to_onehot(32'(idx));
        gnt = any ? oh[N-1:0] : '0;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between pipeline WB (fixed priority)
// and slow units (round-robin), with a starvation guard that forces a slow-unit grant.
module wb_port_arbiter #(
    parameter int unsigned NREQ         = 3,
    parameter int unsigned AW           = wb_arb_pkg::AW,
    parameter int unsigned DW           = wb_arb_pkg::DW,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ZERO_REG     = wb_arb_pkg::ZERO_REG
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [DW-1:0]      wr_data,
    output logic               stall_pipe,
    output logic               starve_active
);

    import wb_arb_pkg::*;

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t        state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] force_idx_q, force_idx_d;
    logic [3:0]    cnt_q [NREQ-1:1];
    logic [3:0]    cnt_d [NREQ-1:1];

    logic [NREQ-1:0] ready_int;
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [IW-1:0]   gnt_idx;
    logic            accept;
    logic            hit;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    logic            wr_en_q;
    logic [AW-1:0]   wr_addr_q;
    logic [DW-1:0]   wr_data_q;

    rr_picker #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr_picker (
        .req (req_valid[NREQ-1:1]),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        force_idx_d = force_idx_q;
        ready_int   = '0;
        gnt_idx     = '0;
        hit         = 1'b0;

        unique case (state_q)
            Normal: begin
                if (req_valid[0]) begin
                    ready_int[0] = 1'b1;
                end else if (pick_any) begin
                    ready_int = pick_gnt;
                    gnt_idx   = pick_idx;
                end
            end
            Force: begin
                // A dropped request here is a protocol violation; just fall back to Normal.
                ready_int[force_idx_q] = req_valid[force_idx_q];
                gnt_idx                = force_idx_q;
                state_d                = Normal;
            end
        endcase

        accept = |ready_int;

        if (accept && gnt_idx != '0) begin
            rr_ptr_d = (32'(gnt_idx) == NREQ - 1) ? IW'(1) : gnt_idx + IW'(1);
        end

        for (int i = 1; i < int'(NREQ); i++) begin
            cnt_d[i] = 4'd0;
            if (req_valid[i] && !ready_int[i]) begin
                cnt_d[i] = (cnt_q[i] == 4'(STARVE_LIMIT)) ? cnt_q[i] : cnt_q[i] + 4'd1;
            end
        end

        // Descending scan so the lowest index at the limit is the one latched.
        if (state_q == Normal) begin
            for (int i = int'(NREQ) - 1; i >= 1; i--) begin
                if (cnt_d[i] == 4'(STARVE_LIMIT)) begin
                    hit         = 1'b1;
                    force_idx_d = IW'(i);
                end
            end
            if (hit) begin
                state_d = Force;
            end
        end

        sel_addr = req_addr[32'(gnt_idx) * AW +: AW];
        sel_data = req_data[32'(gnt_idx) * DW +: DW];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= Normal;
            rr_ptr_q    <= IW'(1);
            force_idx_q <= '0;
            for (int i = 1; i < int'(NREQ); i++) begin
                cnt_q[i] <= 4'd0;
            end
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            force_idx_q <= force_idx_d;
            for (int i = 1; i < int'(NREQ); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= accept && (sel_addr != AW'(ZERO_REG));
            if (accept) begin
                wr_addr_q <= sel_addr;
                wr_data_q <= sel_data;
            end
        end
    end

    // Reset gates the combinational handshake outputs so nothing is acked while held.
    assign req_ready     = reset ? '0 : ready_int;
    assign stall_pipe    = !reset && req_valid[0] && !ready_int[0];
    assign starve_active = (state_q == Force);
    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter.
module tb_wb_port_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 64;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic               stall_pipe;
    logic               starve_active;

    int n_chk  = 0;
    int n_fail = 0;

    wb_port_arbiter #(
        .NREQ         (NREQ),
        .AW           (AW),
        .DW           (DW),
        .STARVE_LIMIT (4),
        .ZERO_REG     (31)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .stall_pipe    (stall_pipe),
        .starve_active (starve_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_addr[i*AW +: AW]  = a;
        req_data[i*DW +: DW]  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] rr_rdy  [4] = '{3'b100, 3'b010, 3'b100, 3'b010};
    logic [4:0] rr_adr  [4] = '{5'd12, 5'd10, 5'd12, 5'd10};
    logic [2:0] st_rdy  [8] = '{3'b001, 3'b001, 3'b001, 3'b001,
                                3'b010, 3'b001, 3'b100, 3'b001};
    logic       st_frc  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [4:0] st_adr  [8] = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd2, 5'd1, 5'd4, 5'd1};

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        drive(0, 1'b1, 5'd1, 64'h1);
        #2;
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_stall", 64'(stall_pipe), 64'd0);
        chk("rst_starve", 64'(starve_active), 64'd0);
        chk("rst_wr_data", wr_data, 64'd0);
        tick();
        tick();
        reset = 1'b0;
        drive(0, 1'b0, 5'd0, 64'h0);
        tick();

        // Single slow-unit write, latency one.
        drive(1, 1'b1, 5'd3, 64'hDEAD_BEEF);
        #1;
        chk("a_ready", 64'(req_ready), 64'(3'b010));
        chk("a_stall", 64'(stall_pipe), 64'd0);
        tick();
        drive(1, 1'b0, 5'd0, 64'h0);
        chk("a_wr_en", 64'(wr_en), 64'd1);
        chk("a_wr_addr", 64'(wr_addr), 64'd3);
        chk("a_wr_data", wr_data, 64'hDEAD_BEEF);
        tick();
        chk("a_wr_en_off", 64'(wr_en), 64'd0);
        chk("a_wr_data_hold", wr_data, 64'hDEAD_BEEF);

        // Round-robin alternation between slow units, pointer now at 2.
        drive(1, 1'b1, 5'd10, 64'h11);
        drive(2, 1'b1, 5'd12, 64'h22);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr_ready%0d", k), 64'(req_ready), 64'(rr_rdy[k]));
            chk($sformatf("rr_starve%0d", k), 64'(starve_active), 64'd0);
            tick();
            chk($sformatf("rr_wr_addr%0d", k), 64'(wr_addr), 64'(rr_adr[k]));
        end
        req_valid = '0;
        tick();

        // Write to the zero register is acked but suppressed; pointer is at 2.
        drive(2, 1'b1, 5'd31, 64'h1);
        #1;
        chk("z_ready", 64'(req_ready), 64'(3'b100));
        tick();
        drive(2, 1'b0, 5'd0, 64'h0);
        chk("z_wr_en", 64'(wr_en), 64'd0);
        tick();

        // Back-to-back writes to X7 issue in grant order.
        drive(1, 1'b1, 5'd7, 64'hAAAA);
        #1;
        chk("h_ready1", 64'(req_ready), 64'(3'b010));
        tick();
        drive(1, 1'b0, 5'd0, 64'h0);
        drive(2, 1'b1, 5'd7, 64'hBBBB);
        #1;
        chk("h_wr_en1", 64'(wr_en), 64'd1);
        chk("h_wr_data1", wr_data, 64'hAAAA);
        chk("h_ready2", 64'(req_ready), 64'(3'b100));
        tick();
        drive(2, 1'b0, 5'd0, 64'h0);
        chk("h_wr_en2", 64'(wr_en), 64'd1);
        chk("h_wr_addr2", 64'(wr_addr), 64'd7);
        chk("h_wr_data2", wr_data, 64'hBBBB);
        tick();
        chk("h_wr_en_off", 64'(wr_en), 64'd0);

        // All three valid: pipeline wins until starvation forces req1, then req2.
        drive(0, 1'b1, 5'd1, 64'h100);
        drive(1, 1'b1, 5'd2, 64'h200);
        drive(2, 1'b1, 5'd4, 64'h400);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("s_ready%0d", k), 64'(req_ready), 64'(st_rdy[k]));
            chk($sformatf("s_starve%0d", k), 64'(starve_active), 64'(st_frc[k]));
            chk($sformatf("s_stall%0d", k), 64'(stall_pipe), 64'(st_frc[k]));
            tick();
            chk($sformatf("s_wr_addr%0d", k), 64'(wr_addr), 64'(st_adr[k]));
        end
        req_valid = '0;
        tick();

        // Reset with a registered write pending; pointer moves to 2 before reset.
        drive(1, 1'b1, 5'd5, 64'h55);
        #1;
        chk("r_ready_pre", 64'(req_ready), 64'(3'b010));
        tick();
        chk("r_wr_en_pre", 64'(wr_en), 64'd1);
        chk("r_wr_addr_pre", 64'(wr_addr), 64'd5);
        reset = 1'b1;
        drive(0, 1'b1, 5'd9, 64'h99);
        drive(2, 1'b1, 5'd6, 64'h66);
        #1;
        chk("r_wr_en", 64'(wr_en), 64'd0);
        chk("r_wr_addr", 64'(wr_addr), 64'd0);
        chk("r_wr_data", wr_data, 64'd0);
        chk("r_ready", 64'(req_ready), 64'd0);
        chk("r_stall", 64'(stall_pipe), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("r_first_grant", 64'(req_ready), 64'(3'b001));
        tick();
        chk("r_first_addr", 64'(wr_addr), 64'd9);
        drive(0, 1'b0, 5'd0, 64'h0);
        #1;
        chk("r_ptr_reset", 64'(req_ready), 64'(3'b010));
        tick();
        req_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
